// File: rtl/anu_rv32_core.sv
// Single-cycle RV32I core: one instruction retires per non-stalled rising edge; fetch/load data are combinational.
// Backpressure: stall freezes PC and register file and suppresses stores; outputs still follow the current instruction.
module anu_rv32_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [31:0] instr,
    input  logic [31:0] data_in,
    output logic [31:0] pc_o,
    output logic [31:0] data_out,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_access_mode
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [31:0] pc_q, pc_d, pc_plus4;
    logic [31:0] rf_q [32];

    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, alu_b, alu_res, ld_dat, wb_dat;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        ld_ok, op_ok, br_taken, wb_en;
    logic [1:0]  st_mode;

    assign opc = instr[6:0];
    assign rd  = instr[11:7];
    assign f3  = instr[14:12];
    assign rs1 = instr[19:15];
    assign rs2 = instr[24:20];
    assign f7  = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
    assign pc_plus4 = pc_q + 32'd4;
    assign pc_o     = pc_q;
    assign data_out = rs2_val;
    assign mem_addr = rs1_val + ((opc == OPC_STORE) ? imm_s : imm_i);
    assign mem_access_mode = (stall || !rst_n) ? 2'b00 : st_mode;

    // OP-IMM and OP share the ALU; instr[30] selects SUB only for OP, SRA/SRAI for both.
    assign alu_b = (opc == OPC_OP) ? rs2_val : imm_i;
    assign op_ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));

    always_comb begin
        alu_res = 32'd0;
        case (f3)
            3'b000: alu_res = (opc == OPC_OP && instr[30]) ? rs1_val - alu_b : rs1_val + alu_b;
            3'b001: alu_res = rs1_val << alu_b[4:0];
            3'b010: alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
            3'b011: alu_res = {31'd0, rs1_val < alu_b};
            3'b100: alu_res = rs1_val ^ alu_b;
            3'b101: alu_res = instr[30] ? $unsigned($signed(rs1_val) >>> alu_b[4:0])
                                        : rs1_val >> alu_b[4:0];
            3'b110: alu_res = rs1_val | alu_b;
            default: alu_res = rs1_val & alu_b;
        endcase
    end

    always_comb begin
        ld_byte = data_in[7:0];
        case (mem_addr[1:0])
            2'd1:    ld_byte = data_in[15:8];
            2'd2:    ld_byte = data_in[23:16];
            2'd3:    ld_byte = data_in[31:24];
            default: ld_byte = data_in[7:0];
        endcase
        ld_half = mem_addr[1] ? data_in[31:16] : data_in[15:0];
        ld_ok   = 1'b1;
        ld_dat  = data_in;
        case (f3)
            3'b000: ld_dat = {{24{ld_byte[7]}}, ld_byte};
            3'b001: ld_dat = {{16{ld_half[15]}}, ld_half};
            3'b010: ld_dat = data_in;
            3'b100: ld_dat = {24'd0, ld_byte};
            3'b101: ld_dat = {16'd0, ld_half};
            default: ld_ok = 1'b0;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (f3)
            3'b000: br_taken = (rs1_val == rs2_val);
            3'b001: br_taken = (rs1_val != rs2_val);
            3'b100: br_taken = ($signed(rs1_val) < $signed(rs2_val));
            3'b101: br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110: br_taken = (rs1_val < rs2_val);
            3'b111: br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        wb_en   = 1'b0;
        wb_dat  = alu_res;
        pc_d    = pc_plus4;
        st_mode = 2'b00;
        case (opc)
            OPC_LUI:    begin wb_en = 1'b1; wb_dat = imm_u; end
            OPC_AUIPC:  begin wb_en = 1'b1; wb_dat = pc_q + imm_u; end
            OPC_JAL:    begin wb_en = 1'b1; wb_dat = pc_plus4; pc_d = pc_q + imm_j; end
            OPC_JALR:   begin wb_en = 1'b1; wb_dat = pc_plus4; pc_d = (rs1_val + imm_i) & ~32'd1; end
            OPC_BRANCH: if (br_taken) pc_d = pc_q + imm_b;
            OPC_LOAD:   begin wb_en = ld_ok; wb_dat = ld_dat; end
            OPC_STORE: begin
                case (f3)
                    3'b000:  st_mode = 2'b01;
                    3'b001:  st_mode = 2'b10;
                    3'b010:  st_mode = 2'b11;
                    default: st_mode = 2'b00;
                endcase
            end
            OPC_OPIMM:  wb_en = 1'b1;
            OPC_OP:     wb_en = op_ok;
            default:    wb_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (!stall) begin
            pc_q <= pc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else if (!stall && wb_en && rd != 5'd0) begin
            rf_q[rd] <= wb_dat;
        end
    end
endmodule

// File: tb/tb_anu_rv32_core.sv
// Directed bench for anu_rv32_core: instructions are fed per cycle, registers observed through stalled stores.
module tb_anu_rv32_core;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [31:0] instr;
    logic [31:0] data_in;
    logic [31:0] pc_o;
    logic [31:0] data_out;
    logic [31:0] mem_addr;
    logic [1:0]  mem_access_mode;

    int n_checks = 0;
    int n_errs   = 0;

    anu_rv32_core #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .instr           (instr),
        .data_in         (data_in),
        .pc_o            (pc_o),
        .data_out        (data_out),
        .mem_addr        (mem_addr),
        .mem_access_mode (mem_access_mode)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] din);
        instr   = ins;
        data_in = din;
        #1;
    endtask

    // Apply one instruction, check the PC it is fetched from, then retire it.
    task automatic step(input string tag, input logic [31:0] ins, input logic [31:0] exp_pc);
        drive(ins, 32'h0);
        check_eq(tag, pc_o, exp_pc);
        tick;
    endtask

    // Read a register through sw xr,0(x0) with stall held, so no state changes.
    task automatic check_reg(input int r, input logic [31:0] exp);
        stall = 1'b1;
        drive(32'h0000_2023 | (32'(r) << 20), 32'h0);
        check_eq($sformatf("x%0d", r), data_out, exp);
        check_eq("stall_rd_mode", {30'd0, mem_access_mode}, 32'd0);
        stall = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        instr = 32'h0020_2423;
        data_in = 32'h0;
        #1;
        check_eq("rst_pc", pc_o, 32'h0);
        check_eq("rst_mode", {30'd0, mem_access_mode}, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // addi / add / sw
        step("pc_addi", 32'h0050_0093, 32'h0);
        step("pc_add",  32'h0010_8133, 32'h4);
        drive(32'h0020_2423, 32'h0);
        check_eq("pc_sw",      pc_o, 32'h8);
        check_eq("sw_addr",    mem_addr, 32'h8);
        check_eq("sw_data",    data_out, 32'd10);
        check_eq("sw_mode",    {30'd0, mem_access_mode}, 32'd3);
        tick;

        // lb / lbu lane 1 of 0x0000F080, lh upper half of 0x8001F080
        drive(32'h0010_0183, 32'h0000_F080);
        check_eq("lb_addr", mem_addr, 32'h1);
        check_eq("lb_mode", {30'd0, mem_access_mode}, 32'd0);
        tick;
        drive(32'h0030_2023, 32'h0);
        check_eq("lb_sext", data_out, 32'hFFFF_FFF0);
        tick;
        drive(32'h0010_4183, 32'h0000_F080);
        tick;
        drive(32'h0030_2023, 32'h0);
        check_eq("lbu_zext", data_out, 32'h0000_00F0);
        tick;
        drive(32'h0020_1203, 32'h8001_F080);
        check_eq("pc_lh", pc_o, 32'd28);
        tick;
        check_reg(4, 32'hFFFF_8001);

        // Asynchronous reset in the middle of a store cycle
        drive(32'h0020_2423, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_pc",   pc_o, 32'h0);
        check_eq("async_rst_mode", {30'd0, mem_access_mode}, 32'd0);
        tick;
        rst_n = 1'b1;
        for (int r = 1; r < 32; r++) check_reg(r, 32'h0);

        // ALU comparisons, then control flow
        step("pc_addi_m1", 32'hFFF0_0293, 32'h00);
        step("pc_sltiu",   32'hFFF0_3313, 32'h04);
        step("pc_slt",     32'h0002_A3B3, 32'h08);
        step("pc_sltu",    32'h0002_B4B3, 32'h0C);
        step("pc_beq",     32'h0000_0463, 32'h10);
        step("pc_jal",     32'hFF1F_F0EF, 32'h18);
        step("pc_jalr",    32'h0030_8067, 32'h08);
        step("pc_lui",     32'h8000_0537, 32'h1E);
        step("pc_srai",    32'h4045_5593, 32'h22);
        step("pc_srli",    32'h0045_5613, 32'h26);
        step("pc_sub",     32'h4050_06B3, 32'h2A);
        step("pc_auipc",   32'h0000_1717, 32'h2E);
        step("pc_blt",     32'h0002_C463, 32'h32);
        step("pc_bltu",    32'h0002_E463, 32'h3A);
        check_reg(1,  32'h0000_001C);
        check_reg(5,  32'hFFFF_FFFF);
        check_reg(6,  32'h1);
        check_reg(7,  32'h1);
        check_reg(9,  32'h0);
        check_reg(10, 32'h8000_0000);
        check_reg(11, 32'hF800_0000);
        check_reg(12, 32'h0800_0000);
        check_reg(13, 32'h1);
        check_reg(14, 32'h0000_102E);

        // Store held by stall for three cycles, then released once
        stall = 1'b1;
        drive(32'h0010_2023, 32'h0);
        for (int c = 0; c < 3; c++) begin
            check_eq("stall_pc",   pc_o, 32'h3E);
            check_eq("stall_mode", {30'd0, mem_access_mode}, 32'd0);
            tick;
        end
        stall = 1'b0;
        #1;
        check_eq("rel_pc",   pc_o, 32'h3E);
        check_eq("rel_mode", {30'd0, mem_access_mode}, 32'd3);
        check_eq("rel_data", data_out, 32'h1C);
        tick;

        // Write to x0 is discarded
        drive(32'h0070_0013, 32'h0);
        check_eq("x0w_pc",   pc_o, 32'h42);
        check_eq("x0w_mode", {30'd0, mem_access_mode}, 32'd0);
        tick;
        drive(32'h0000_2023, 32'h0);
        check_eq("x0_pc",   pc_o, 32'h46);
        check_eq("x0_data", data_out, 32'h0);
        tick;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
